div_array_seq: RTL



---
 rtl/riscv_v_alu_pkg.sv | 15 +
 rtl/adder_nbit.sv | 61 ++++++
 rtl/div_step.sv | 39 +++
 rtl/div_array_seq.sv | 108 ++++++++++
 4 files changed

// File: rtl/riscv_v_alu_pkg.sv
// Shared definitions for the integer execution unit: divider FSM encoding
// and the divide-by-zero result convention used by every divide flavour.
package riscv_v_alu_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // A zero divisor yields an all-ones quotient (replicate this bit to the
  // operand width) and returns the dividend unchanged as the remainder.
  localparam logic DIV0_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/adder_nbit.sv
// N-bit adder with carry in/out; behavioral, ripple-carry or
// carry-lookahead implementation selected by parameter.
module adder_nbit #(
  parameter int N            = 8,
  parameter bit BEHAVIORAL   = 1'b0,
  parameter bit RIPPLE_CARRY = 1'b1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  generate
    if (BEHAVIORAL) begin : g_behav
      assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    end else begin : g_struct
      logic [N-1:0] g;
      logic [N-1:0] p;
      logic [N:0]   c;

      assign g = a & b;
      assign p = a ^ b;

      if (RIPPLE_CARRY) begin : g_ripple
        always_comb begin
          c    = '0;
          c[0] = cin;
          for (int i = 0; i < N; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
          end
        end
      end else begin : g_cla
        // Each carry is a flat sum of generate terms so no carry depends on another.
        always_comb begin
          logic carry;
          logic term;
          c     = '0;
          carry = 1'b0;
          term  = 1'b0;
          c[0]  = cin;
          for (int i = 0; i < N; i++) begin
            carry = cin;
            for (int j = 0; j <= i; j++) carry = carry & p[j];
            for (int j = 0; j <= i; j++) begin
              term = g[j];
              for (int k = j + 1; k <= i; k++) term = term & p[k];
              carry = carry | term;
            end
            c[i+1] = carry;
          end
        end
      end

      assign sum  = p ^ c[N-1:0];
      assign cout = c[N];
    end
  endgenerate

endmodule

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not borrow.
module div_step #(
  parameter int WIDTH        = 8,
  parameter bit BEHAVIORAL   = 1'b0,
  parameter bit RIPPLE_CARRY = 1'b1
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] next_rem,
  output logic             qbit
);

  logic [WIDTH:0] s;
  logic [WIDTH:0] d;
  logic           no_borrow;
  logic           unused_d_msb;

  assign s = {rem, dividend_msb};

  adder_nbit #(
    .N           (WIDTH + 1),
    .BEHAVIORAL  (BEHAVIORAL),
    .RIPPLE_CARRY(RIPPLE_CARRY)
  ) u_sub (
    .a   (s),
    .b   (~{1'b0, b}),
    .cin (1'b1),
    .sum (d),
    .cout(no_borrow)
  );

  // The partial remainder stays below the divisor, so a kept difference fits in WIDTH bits.
  assign unused_d_msb = d[WIDTH];
  assign qbit         = no_borrow;
  assign next_rem     = no_borrow ? d[WIDTH-1:0] : s[WIDTH-1:0];

endmodule

// File: rtl/div_array_seq.sv
// Iterative unsigned restoring divider: one quotient bit per clock,
// WIDTH cycles from accept to done, start/done handshake.
module div_array_seq
  import riscv_v_alu_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter bit BEHAVIORAL   = 1'b0,
  parameter bit RIPPLE_CARRY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]   COUNT_INIT = CW'(WIDTH - 1);

  div_state_e       state, next_state;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic             accept;
  logic             b_is_zero;
  logic [WIDTH-1:0] next_dividend;

  assign b_is_zero     = (B == '0);
  assign accept        = start && (state != DIV_CALC);
  assign next_dividend = {dividend_q[WIDTH-2:0], step_qbit};

  div_step #(
    .WIDTH       (WIDTH),
    .BEHAVIORAL  (BEHAVIORAL),
    .RIPPLE_CARRY(RIPPLE_CARRY)
  ) u_step (
    .rem         (rem_q),
    .dividend_msb(dividend_q[WIDTH-1]),
    .b           (divisor_q),
    .next_rem    (step_rem),
    .qbit        (step_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIV_IDLE;
    else     state <= next_state;
  end

  // A division-by-zero request skips CALC entirely and reports in the very next cycle.
  always_comb begin
    next_state = state;
    case (state)
      DIV_IDLE, DIV_DONE: begin
        if (start) next_state = b_is_zero ? DIV_DONE : DIV_CALC;
        else       next_state = DIV_IDLE;
      end
      DIV_CALC: begin
        if (count == '0) next_state = DIV_DONE;
      end
      default: next_state = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (b_is_zero) begin
        quotient    <= {WIDTH{DIV0_QUOTIENT_BIT}};
        remainder   <= A;
        div_by_zero <= 1'b1;
      end else begin
        dividend_q  <= A;
        divisor_q   <= B;
        rem_q       <= '0;
        count       <= COUNT_INIT;
        div_by_zero <= 1'b0;
      end
    end else if (state == DIV_CALC) begin
      dividend_q <= next_dividend;
      rem_q      <= step_rem;
      count      <= count - 1'b1;
      // Results only move on the final step so they stay stable between operations.
      if (count == '0) begin
        quotient  <= next_dividend;
        remainder <= step_rem;
      end
    end
  end

  assign busy = (state == DIV_CALC);
  assign done = (state == DIV_DONE);

endmodule
